dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//  Data-memory responder serving load/store requests from the CPU datapath over a valid/ready handshake.
//  Replaces the zero-latency dm array for multi-cycle CPU variants.
//  Accepts one request at a time, inserts programmable wait states, and returns read data or a write acknowledge.
//  Flags misaligned and out-of-range accesses with an error bit.
// PARAMETERS
//  DEPTH_WORDS  1024           number of 32-bit words in storage
//  ADDR_BASE    32'h0000_0000  byte address mapped to word 0
//  WAIT_CYCLES  2              wait states inserted before access; legal range 0..15
// PORTS
//  clock       in   1   single clock; all state updates on rising edge
//  reset       in   1   asynchronous, active-high; clears all state except the storage array
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept; registered
//  req_write   in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data
//  req_be      in   4   byte lane enables; used only with DM_BYTE_LANE_EN
//  resp_valid  out  1   response present
//  resp_ready  in   1   consumer accepts response
//  resp_rdata  out  32  load data; 0 for stores and errors
//  resp_err    out  1   misaligned (addr[1:0]!=0) or address outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS)
// BEHAVIOUR
//  Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE. The storage array is not cleared.
//  req_ready rises on the first edge after reset deasserts. It is 1 only in IDLE.
//  FSM states are IDLE, WAIT, ACCESS and RESP.
//   IDLE: on req_valid&&req_ready, latch write, addr, wdata and be, and compute err. Then:
//     go to WAIT with cnt=WAIT_CYCLES if WAIT_CYCLES>0;
//     otherwise go to ACCESS.
//     req_ready drops on the same edge.
//   WAIT: cnt decrements each cycle. Go to ACCESS on the edge where cnt==1.
//   ACCESS: lasts one cycle. The write commits to the array on its closing edge when write && !err.
//     The read word is registered into resp_rdata (0 if write or err). Then go to RESP.
//   RESP: resp_valid=1. resp_rdata and resp_err stay stable until resp_valid&&resp_ready.
//     On that edge: resp_valid=0, req_ready=1, go to IDLE.
//  Latency: resp_valid rises WAIT_CYCLES+1 edges after the accept edge, given resp_ready was 1.
//  Back-pressure: resp_ready=0 holds RESP indefinitely. No new request is accepted meanwhile.
//  Back-to-back: the earliest next accept is the edge after the response handshake.
//  Word index = (req_addr-ADDR_BASE)>>2. The subtraction is 32-bit unsigned.
//   An address below ADDR_BASE wraps to a large value and fails the range check, giving err.
//  An error store never modifies the array. An error load returns rdata=0.
//  Read-after-write to the same word in consecutive transactions returns the new data.
//  Asynchronous reset in WAIT or ACCESS (before its closing edge): the transaction is dropped,
//   no array write occurs, and no response is issued.
//  Asynchronous reset in RESP: the response is lost, and resp_valid clears immediately.
//  req_valid while reset is asserted is ignored.
// CONFIGURATION
//  Macro DM_BYTE_LANE_EN:
//   Defined: a store writes only the lanes with req_be[i]=1 (lane 0 = bits 7:0).
//     be=4'b0000 performs no write but still acknowledges.
//     Loads always return the full word.
//   Undefined: req_be is ignored, and every store writes all 32 bits.
// STRUCTURE
//  Package dm_pkg holds:
//   the state encoding constants (IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2, RESP=2'd3);
//   WAIT_W=4, the wait counter width;
//   the word and byte-enable width constants.
//  Sub-module dm_sram: DEPTH_WORDS x 32 array with a synchronous write (per-lane when DM_BYTE_LANE_EN)
//   and a registered read; it is instantiated once.
//  The FSM, wait counter, error check and response registers stay in dm_responder.
// TESTING
//  T1 store then load, WAIT_CYCLES=2, resp_ready=1:
//   store addr=0x10, wdata=0xDEADBEEF -> resp_valid 3 edges after accept, err=0, rdata=0.
//   Then load 0x10 -> rdata=0xDEADBEEF.
//  T2 WAIT_CYCLES=0: load accepted at edge N -> resp_valid high after edge N+1. No WAIT state is visited.
//  T3 misaligned store to 0x12 -> err=1, rdata=0. A following load of 0x10 still returns 0xDEADBEEF.
//  T4 out-of-range load at ADDR_BASE+4*DEPTH_WORDS, and a load at ADDR_BASE-4 -> err=1, rdata=0 for both.
//  T5 back-pressure: hold resp_ready=0 for 5 cycles ->
//   resp_valid, rdata and err are stable, req_ready=0, and a req_valid pulse is not accepted.
//   Release -> handshake, then IDLE.
//  T6 reset asserted mid-WAIT on a store of 0x12345678 to 0x20 ->
//   all outputs go to reset values immediately. After reset, a load of 0x20 returns the old contents.
//   With DM_BYTE_LANE_EN, also check: be=4'b0011 with wdata 0xAABBCCDD over 0xDEADBEEF -> 0xDEADCCDD.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared state encoding and widths for the data-memory responder
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dm_state_e;

  localparam int WAIT_W = 4;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

endpackage

// File: rtl/dm_sram.sv
// rtl/dm_sram.sv - word array with synchronous write and registered read
// DM_BYTE_LANE_EN selects per-lane stores; otherwise every store writes the full word.
module dm_sram
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [AW-1:0]     rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH_WORDS);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

`ifdef DM_BYTE_LANE_EN
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end
`else
  logic unused_be;
  assign unused_be = ^wr_be;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end
`endif

  // Indices past a non-power-of-two depth read as zero; the caller masks them as errors anyway.
  always_ff @(posedge clock) begin
    rd_data <= ({1'b0, rd_idx} < DEPTH_L) ? mem[rd_idx] : '0;
  end

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - load/store responder with programmable wait states and error flag
// Optional DM_BYTE_LANE_EN enables byte-lane stores in dm_sram.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  dm_state_e         state, state_next;
  logic [WAIT_W-1:0] cnt;
  logic              write_q, err_q;
  logic [AW-1:0]     idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;

  logic              accept;
  logic [31:0]       offset;
  logic              req_err;
  logic [AW-1:0]     req_idx;
  logic [AW-1:0]     rd_idx;
  logic [31:0]       sram_rdata;
  logic              sram_we;

  // Unsigned wrap makes addresses below the base land far out of range.
  assign accept  = req_valid && req_ready;
  assign offset  = req_addr - ADDR_BASE;
  assign req_err = (req_addr[1:0] != 2'b00) || (offset >= SPAN);
  assign req_idx = offset[AW+1:2];

  // The read is launched on the accept edge so data is ready even with zero wait states.
  assign rd_idx  = (state == IDLE) ? req_idx : idx_q;
  assign sram_we = (state == ACCESS) && write_q && !err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
      WAIT:    if (cnt == WAIT_W'(1)) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (resp_valid && resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      req_ready  <= (state_next == IDLE);
      resp_valid <= (state_next == RESP);
      if (accept) begin
        write_q <= req_write;
        err_q   <= req_err;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
        be_q    <= req_be;
        cnt     <= WAIT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - WAIT_W'(1);
      end
      if (state == ACCESS) begin
        resp_rdata <= (write_q || err_q) ? '0 : sram_rdata;
        resp_err   <= err_q;
      end
    end
  end

  dm_sram #(
    .DEPTH_WORDS (int'(DEPTH_WORDS)),
    .AW          (AW)
  ) u_sram (
    .clock   (clock),
    .wr_en   (sram_we),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .wr_be   (be_q),
    .rd_idx  (rd_idx),
    .rd_data (sram_rdata)
  );

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - self-checking bench for dm_responder (two configurations)
module tb_dm_responder;

  localparam logic [31:0] B_BASE  = 32'h0000_1000;
  localparam int unsigned B_DEPTH = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = 4'hF;

  logic        a_req_ready, a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;

  logic        req_ready_m, resp_valid_m, resp_err_m;
  logic [31:0] resp_rdata_m;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_a [int unsigned];
  logic [31:0] mem_b [int unsigned];

  always #5 clock = ~clock;

  dm_responder u_dut_a (
    .clock(clock), .reset(reset),
    .req_valid(req_valid && !sel), .req_ready(a_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready && !sel),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  dm_responder #(.DEPTH_WORDS(B_DEPTH), .ADDR_BASE(B_BASE), .WAIT_CYCLES(0)) u_dut_b (
    .clock(clock), .reset(reset),
    .req_valid(req_valid && sel), .req_ready(b_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready && sel),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  assign req_ready_m  = sel ? b_req_ready  : a_req_ready;
  assign resp_valid_m = sel ? b_resp_valid : a_resp_valid;
  assign resp_rdata_m = sel ? b_resp_rdata : a_resp_rdata;
  assign resp_err_m   = sel ? b_resp_err   : a_resp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [31:0] base, input int unsigned depth);
    logic [31:0] off;
    off = a - base;
    return (a % 4 != 0) || (off >= depth * 4);
  endfunction

  task automatic model_apply(input bit s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] base, old, nw;
    logic [3:0]  eff_be;
    int unsigned k;
    base = s ? B_BASE : 32'h0;
    if (model_err(a, base, s ? B_DEPTH : 1024)) return;
    k = (a - base) / 4;
    if (s) old = mem_b.exists(k) ? mem_b[k] : 'x;
    else   old = mem_a.exists(k) ? mem_a[k] : 'x;
`ifdef DM_BYTE_LANE_EN
    eff_be = be;
`else
    eff_be = be | 4'hF;
`endif
    nw = old;
    for (int i = 0; i < 4; i++) if (eff_be[i]) nw[8*i +: 8] = d[8*i +: 8];
    if (s) mem_b[k] = nw;
    else   mem_a[k] = nw;
  endtask

  // One full transaction; returns the response and the edges from accept to resp_valid.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!req_ready_m && n < 50) begin @(negedge clock); n++; end
    if (n >= 50) check("ready_timeout", {31'b0, req_ready_m}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid_m && lat < 50) begin @(posedge clock); #1; lat++; end
    if (lat >= 50) check("resp_timeout", {31'b0, resp_valid_m}, 32'd1);
    rd = resp_rdata_m;
    er = resp_err_m;
    if (resp_ready) begin
      @(posedge clock); #1;
      check("hs_valid_clr", {31'b0, resp_valid_m}, 32'd0);
      check("hs_ready",     {31'b0, req_ready_m},  32'd1);
    end
  endtask

  typedef struct {
    bit          s;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit s, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic e, input logic [31:0] r);
    vec_t v;
    v.s = s; v.w = w; v.addr = a; v.wdata = d; v.be = 4'hF;
    v.exp_err = e; v.exp_rdata = r; v.exp_lat = s ? 1 : 3;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_rd, pool [4];
    logic        er, e;
    int          lat;

    // Main config: 1024 words at base 0, two wait states. Second config: 64 words at 0x1000, none.
    add_vec(0, 1, 32'h0000_0010, 32'hDEADBEEF, 0, 32'h0);
    add_vec(0, 0, 32'h0000_0010, 32'h0,        0, 32'hDEADBEEF);
    add_vec(0, 1, 32'h0000_0012, 32'h1111_1111, 1, 32'h0);
    add_vec(0, 0, 32'h0000_0010, 32'h0,        0, 32'hDEADBEEF);
    add_vec(0, 0, 32'h0000_1000, 32'h0,        1, 32'h0);
    add_vec(0, 0, 32'hFFFF_FFFC, 32'h0,        1, 32'h0);
    add_vec(0, 1, 32'h0000_0020, 32'hCAFEF00D, 0, 32'h0);
    add_vec(0, 0, 32'h0000_0020, 32'h0,        0, 32'hCAFEF00D);
    add_vec(0, 1, 32'h0000_0FFC, 32'h0BADC0DE, 0, 32'h0);
    add_vec(0, 0, 32'h0000_0FFC, 32'h0,        0, 32'h0BADC0DE);
    add_vec(0, 1, 32'h0000_1000, 32'h5555_5555, 1, 32'h0);
    add_vec(0, 1, 32'h0000_0000, 32'hA5A5A5A5, 0, 32'h0);
    add_vec(0, 0, 32'h0000_0000, 32'h0,        0, 32'hA5A5A5A5);
    add_vec(0, 0, 32'h0000_0011, 32'h0,        1, 32'h0);
    add_vec(1, 1, 32'h0000_1004, 32'h1234ABCD, 0, 32'h0);
    add_vec(1, 0, 32'h0000_1004, 32'h0,        0, 32'h1234ABCD);
    add_vec(1, 0, 32'h0000_0FFC, 32'h0,        1, 32'h0);
    add_vec(1, 0, 32'h0000_1100, 32'h0,        1, 32'h0);
    add_vec(1, 1, 32'h0000_10FC, 32'h7777_0001, 0, 32'h0);
    add_vec(1, 0, 32'h0000_10FC, 32'h0,        0, 32'h7777_0001);

    #12;
    check("rst_req_ready",  {31'b0, a_req_ready},  32'd0);
    check("rst_resp_valid", {31'b0, a_resp_valid}, 32'd0);
    check("rst_resp_rdata", a_resp_rdata,          32'd0);
    check("rst_resp_err",   {31'b0, a_resp_err},   32'd0);
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b0;
    #1 check("rdy_before_edge", {31'b0, a_req_ready}, 32'd0);
    @(posedge clock); #1;
    check("rdy_first_edge", {31'b0, a_req_ready}, 32'd1);
    check("no_resp_after_rst", {31'b0, a_resp_valid}, 32'd0);

    foreach (vecs[i]) begin
      sel = vecs[i].s;
      txn(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      if (vecs[i].w) model_apply(vecs[i].s, vecs[i].addr, vecs[i].wdata, vecs[i].be);
    end
    sel = 1'b0;

    // Back-pressure: response must hold and a stray request must be ignored.
    resp_ready = 1'b0;
    txn(0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    check("bp_first", rd, mem_a[4]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      req_valid = (c == 2); req_write = 1'b0; req_addr = 32'h20;
      @(posedge clock); #1;
      check("bp_valid", {31'b0, a_resp_valid}, 32'd1);
      check("bp_rdata", a_resp_rdata, mem_a[4]);
      check("bp_err",   {31'b0, a_resp_err}, 32'd0);
      check("bp_ready", {31'b0, a_req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_release_valid", {31'b0, a_resp_valid}, 32'd0);
    check("bp_release_ready", {31'b0, a_req_ready}, 32'd1);
    repeat (4) begin
      @(posedge clock); #1;
      check("bp_no_accept", {31'b0, a_resp_valid, a_req_ready}, 32'd1);
    end

    // Reset mid-WAIT drops the store.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("rw_req_ready",  {31'b0, a_req_ready},  32'd0);
    check("rw_resp_valid", {31'b0, a_resp_valid}, 32'd0);
    check("rw_resp_rdata", a_resp_rdata,          32'd0);
    check("rw_resp_err",   {31'b0, a_resp_err},   32'd0);
    @(negedge clock);
    reset = 1'b0;
    txn(0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    check("rw_old_data", rd, mem_a[8]);

    // Reset while a response is waiting clears it immediately.
    resp_ready = 1'b0;
    txn(0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    check("rr_pre_valid", {31'b0, a_resp_valid}, 32'd1);
    reset = 1'b1;
    #1 check("rr_valid_clr", {31'b0, a_resp_valid}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    resp_ready = 1'b1;

    // Lane enables: partial store, then an empty store that only acknowledges.
    txn(1, 32'h30, 32'hDEADBEEF, 4'hF, rd, er, lat);
    model_apply(0, 32'h30, 32'hDEADBEEF, 4'hF);
    txn(1, 32'h30, 32'hAABBCCDD, 4'b0011, rd, er, lat);
    model_apply(0, 32'h30, 32'hAABBCCDD, 4'b0011);
    check("be_ack_err", {31'b0, er}, 32'd0);
    txn(0, 32'h30, 32'h0, 4'hF, rd, er, lat);
`ifdef DM_BYTE_LANE_EN
    check("be_partial", rd, 32'hDEADCCDD);
    txn(1, 32'h30, 32'h0102_0304, 4'b0000, rd, er, lat);
    model_apply(0, 32'h30, 32'h0102_0304, 4'b0000);
    check("be_none_err", {31'b0, er}, 32'd0);
    txn(0, 32'h30, 32'h0, 4'hF, rd, er, lat);
    check("be_none_keep", rd, 32'hDEADCCDD);
`else
    check("be_ignored", rd, 32'hAABBCCDD);
`endif

    // Random traffic against the reference model.
    pool[0] = 32'h0; pool[1] = 32'h10; pool[2] = 32'h20; pool[3] = 32'hFFC;
    for (int t = 0; t < 60; t++) begin
      logic        w;
      logic [31:0] a, d;
      logic [3:0]  be;
      int          k;
      k  = $urandom_range(0, 6);
      w  = 1'($urandom_range(0, 1));
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      case (k)
        0, 1, 2, 3: a = pool[k];
        4:          a = pool[$urandom_range(0, 3)] + $urandom_range(1, 3);
        5:          a = 32'h1000 + 4 * $urandom_range(0, 1000);
        default:    a = 32'hFFFF_0000 | ($urandom & 32'h0000_FFFC);
      endcase
      e = model_err(a, 32'h0, 1024);
      exp_rd = 32'h0;
      if (!w && !e && mem_a.exists(a / 4)) exp_rd = mem_a[a / 4];
      txn(w, a, d, be, rd, er, lat);
      check($sformatf("rnd%0d_err", t), {31'b0, er}, {31'b0, e});
      if (w || e || mem_a.exists(a / 4)) check($sformatf("rnd%0d_rdata", t), rd, exp_rd);
      check($sformatf("rnd%0d_lat", t), lat, 3);
      if (w) model_apply(0, a, d, be);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
